// File: rtl/instruction_encoder.sv
// instruction_encoder: packs discrete instruction fields into a 32-bit
// semi_cpu instruction word and buffers encoded words in a small FIFO.
//
// Handshakes (both sides use strict valid/ready semantics):
//   - Input side: a bundle is accepted on a rising edge where
//     in_valid && in_ready. in_ready depends only on occupancy.
//   - Output side: a word is popped on a rising edge where
//     control && instr_ready. instruction holds steady while stalled.
//   - Neither valid depends combinationally on its ready.
module instruction_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [31:0]      in_imm,
  output logic [31:0]      instruction,
  output logic             control,
  input  logic             instr_ready,
  output logic             err_imm_range,
  input  logic             err_clear,
  output logic [CNT_W-1:0] issued_count,
  output logic [CNT_W-1:0] dropped_count,
  output logic [LVL_W-1:0] level
);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] dropped_q, dropped_d;
  logic             err_q, err_d;

  logic [31:0] enc_word;
  logic        imm_legal;
  logic        accept;
  logic        push;
  logic        pop;
  logic        drop;

  // Field packing by opcode class; immediate must sign-extend from bit 18.
  always_comb begin
    enc_word  = '0;
    imm_legal = 1'b1;
    case (in_opcode)
      3'b000, 3'b001: enc_word = {in_opcode, 29'b0};
      3'b110, 3'b111: begin
        enc_word  = {in_opcode, in_rd, in_rs, in_imm[18:0]};
        imm_legal = (&in_imm[31:18]) | ~(|in_imm[31:18]);
      end
      default: enc_word = {in_opcode, in_rd, in_rs, in_rt, 14'b0};
    endcase
  end

  assign in_ready = (level_q != LVL_W'(DEPTH));
  assign control  = (level_q != '0);
  assign accept   = in_valid && in_ready;
  assign push     = accept && imm_legal;
  assign drop     = accept && !imm_legal;
  assign pop      = control && instr_ready;

  // Next-state for pointers, occupancy, counters and the sticky error flag.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    issued_d  = issued_q;
    dropped_d = dropped_q;
    err_d     = err_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      issued_d = issued_q + CNT_W'(1);
    end
    if (push && !pop) level_d = level_q + LVL_W'(1);
    else if (!push && pop) level_d = level_q - LVL_W'(1);
    // A new range error takes priority over a same-cycle clear.
    if (drop) begin
      err_d     = 1'b1;
      dropped_d = dropped_q + CNT_W'(1);
    end else if (err_clear) begin
      err_d = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      issued_q  <= '0;
      dropped_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      issued_q  <= issued_d;
      dropped_q <= dropped_d;
      err_q     <= err_d;
    end
  end

  // FIFO storage; cleared on reset so the head reads zero when empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= enc_word;
    end
  end

  assign instruction   = mem_q[rd_ptr_q];
  assign err_imm_range = err_q;
  assign issued_count  = issued_q;
  assign dropped_count = dropped_q;
  assign level         = level_q;

endmodule
